// File: rtl/matrix_scheduler.sv
// matrix_scheduler: sequences C = A*B cell by cell through one column_processor.
// Operands are latched at start. Each cell is one ready/ack handshake:
// ISSUE -> WAIT -> DRAIN. The finished matrix is held until the host acknowledges it.
module matrix_scheduler #(
    parameter int unsigned size       = 4,
    parameter int unsigned cell_width = 32,
    parameter int unsigned width      = cell_width * size,
    parameter int unsigned mat_width  = width * size
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 in_start,
    input  logic [mat_width-1:0] in_mat_a,
    input  logic [mat_width-1:0] in_mat_b,
    input  logic                 in_ack,
    output logic [mat_width-1:0] out_mat_c,
    output logic                 out_done,
    output logic                 out_cp_ready,
    output logic [width-1:0]     out_cp_row,
    output logic [width-1:0]     out_cp_col,
    input  logic                 in_cp_ready,
    input  logic [width-1:0]     in_cp_cell,
    output logic                 out_cp_ack
);

    localparam int unsigned IDX_W  = (size > 1) ? $clog2(size) : 1;
    localparam int unsigned MAT_AW = (mat_width > 1) ? $clog2(mat_width) : 1;
    localparam int unsigned ROW_AW = (width > 1) ? $clog2(width) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [mat_width-1:0] r_mat_a;
    logic [mat_width-1:0] r_mat_b;
    logic [mat_width-1:0] r_mat_c;
    logic [IDX_W-1:0]     r_i;
    logic [IDX_W-1:0]     r_j;
    logic                 r_done;
    logic                 r_cp_ready;
    logic                 r_cp_ack;
    logic [width-1:0]     r_cp_row;
    logic [width-1:0]     r_cp_col;

    logic [IDX_W-1:0]     w_next_i;
    logic [IDX_W-1:0]     w_next_j;
    logic                 w_last;
    logic [MAT_AW-1:0]    w_c_off;

    // Row i of a row-major matrix is one contiguous vector.
    function automatic logic [width-1:0] f_row(input logic [mat_width-1:0] m,
                                               input logic [IDX_W-1:0]     i);
        logic [MAT_AW-1:0] off;
        off = MAT_AW'(32'(i) * width);
        return m[off +: width];
    endfunction

    // Column j gathers element (k,j) of every row into slot k.
    function automatic logic [width-1:0] f_col(input logic [mat_width-1:0] m,
                                               input logic [IDX_W-1:0]     j);
        logic [width-1:0]  v;
        logic [MAT_AW-1:0] off;
        logic [ROW_AW-1:0] slot;
        v = '0;
        for (int unsigned k = 0; k < size; k++) begin
            off  = MAT_AW'((k * size + 32'(j)) * cell_width);
            slot = ROW_AW'(k * cell_width);
            v[slot +: cell_width] = m[off +: cell_width];
        end
        return v;
    endfunction

    // Row-major index advance and the position of the current cell in C.
    assign w_last   = (r_i == LAST_IDX) && (r_j == LAST_IDX);
    assign w_next_j = (r_j == LAST_IDX) ? '0 : r_j + 1'b1;
    assign w_next_i = (r_j == LAST_IDX) ? r_i + 1'b1 : r_i;
    assign w_c_off  = MAT_AW'((32'(r_i) * size + 32'(r_j)) * cell_width);

    // Sequencer state, latched operands, result matrix and all registered outputs.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state    <= S_IDLE;
            r_mat_a    <= '0;
            r_mat_b    <= '0;
            r_mat_c    <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_done     <= 1'b0;
            r_cp_ready <= 1'b0;
            r_cp_ack   <= 1'b0;
            r_cp_row   <= '0;
            r_cp_col   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_start) begin
                        r_mat_a    <= in_mat_a;
                        r_mat_b    <= in_mat_b;
                        r_mat_c    <= '0;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_cp_ready <= 1'b1;
                        r_cp_row   <= f_row(in_mat_a, '0);
                        r_cp_col   <= f_col(in_mat_b, '0);
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cp_ready <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (in_cp_ready) begin
                        r_mat_c[w_c_off +: cell_width] <= in_cp_cell[cell_width-1:0];
                        r_cp_ack <= 1'b1;
                        r_state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Hold ack until the processor's ready has actually fallen.
                    if (!in_cp_ready) begin
                        r_cp_ack <= 1'b0;
                        r_i      <= w_next_i;
                        r_j      <= w_next_j;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cp_ready <= 1'b1;
                            r_cp_row   <= f_row(r_mat_a, w_next_i);
                            r_cp_col   <= f_col(r_mat_b, w_next_j);
                            r_state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (in_ack) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_mat_c    = r_mat_c;
    assign out_done     = r_done;
    assign out_cp_ready = r_cp_ready;
    assign out_cp_row   = r_cp_row;
    assign out_cp_col   = r_cp_col;
    assign out_cp_ack   = r_cp_ack;

endmodule
